// File: rtl/risc_ctrl_seq_if.sv
// Control bundle between the sequencer and the rest of the accumulator core:
// run/step/opcode/zero-flag in, datapath strobes and status out.
interface risc_ctrl_seq_if #(
    parameter int CNTW = 8
);
    // run is a level, step a one-cycle pulse honoured only while paused;
    // strobes are valid for the whole cycle they are asserted and need no ack.
    logic            run;
    logic            step;
    logic [2:0]      opcd;
    logic            zr;
    logic            sel;
    logic            rd;
    logic            ld_ir;
    logic            inc_pc;
    logic            ld_pc;
    logic            ld_ac;
    logic            data_e;
    logic            wr;
    logic            halt;
    logic            paused;
    logic [2:0]      phase;
    logic            instr_done;
    logic [CNTW-1:0] instr_cnt;

    modport master (
        output run, step, opcd, zr,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr,
        input  halt, paused, phase, instr_done, instr_cnt
    );

    modport slave (
        input  run, step, opcd, zr,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr,
        output halt, paused, phase, instr_done, instr_cnt
    );
endinterface

// File: rtl/risc_ctrl_seq.sv
// Eight-phase instruction sequencer for the 8-bit accumulator core, with
// run/single-step control and a saturating retired-instruction counter.
module risc_ctrl_seq #(
    parameter int CNTW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    risc_ctrl_seq_if.slave        bus,
    output logic [3:0]            o_dbg_state
);
    // P0..P7 encode their own phase number in the low three bits.
    typedef enum logic [3:0] {
        S_P0    = 4'd0,
        S_P1    = 4'd1,
        S_P2    = 4'd2,
        S_P3    = 4'd3,
        S_P4    = 4'd4,
        S_P5    = 4'd5,
        S_P6    = 4'd6,
        S_P7    = 4'd7,
        S_PAUSE = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    state_t          r_state;
    state_t          w_next;
    logic [CNTW-1:0] r_cnt;
    logic            w_aluop;
    logic            w_sel, w_rd, w_ld_ir, w_inc_pc, w_ld_pc, w_ld_ac;
    logic            w_data_e, w_wr, w_halt, w_paused, w_done;
    logic [2:0]      w_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PAUSE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_P7 && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_PAUSE: if (bus.run || bus.step) w_next = S_P0;
            S_P0:    w_next = S_P1;
            S_P1:    w_next = S_P2;
            S_P2:    w_next = S_P3;
            S_P3:    w_next = S_P4;
            S_P4:    w_next = (bus.opcd == 3'b000) ? S_HALT : S_P5;
            S_P5:    w_next = S_P6;
            S_P6:    w_next = S_P7;
            S_P7:    w_next = bus.run ? S_P0 : S_PAUSE;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_PAUSE;
        endcase
    end

    assign w_aluop = (bus.opcd == 3'b010) || (bus.opcd == 3'b011) ||
                     (bus.opcd == 3'b100) || (bus.opcd == 3'b101);

    always_comb begin
        w_sel    = 1'b0;
        w_rd     = 1'b0;
        w_ld_ir  = 1'b0;
        w_inc_pc = 1'b0;
        w_ld_pc  = 1'b0;
        w_ld_ac  = 1'b0;
        w_data_e = 1'b0;
        w_wr     = 1'b0;
        w_halt   = 1'b0;
        w_paused = 1'b0;
        w_done   = 1'b0;
        w_phase  = r_state[2:0];
        case (r_state)
            S_PAUSE: begin
                w_sel    = 1'b1;
                w_paused = 1'b1;
                w_phase  = 3'd0;
            end
            S_P0: w_sel = 1'b1;
            S_P1: begin
                w_sel = 1'b1;
                w_rd  = 1'b1;
            end
            S_P2, S_P3: begin
                w_sel   = 1'b1;
                w_rd    = 1'b1;
                w_ld_ir = 1'b1;
            end
            S_P4: begin
                w_inc_pc = (bus.opcd != 3'b000);
                w_halt   = (bus.opcd == 3'b000);
            end
            S_P5: w_rd = w_aluop;
            S_P6: begin
                // SKZ skips by a second PC increment; zr is only looked at here.
                w_rd     = w_aluop;
                w_inc_pc = (bus.opcd == 3'b001) && bus.zr;
                w_ld_pc  = (bus.opcd == 3'b111);
                w_data_e = (bus.opcd == 3'b110);
            end
            S_P7: begin
                w_rd     = w_aluop;
                w_ld_ac  = w_aluop;
                w_ld_pc  = (bus.opcd == 3'b111);
                w_data_e = (bus.opcd == 3'b110);
                w_wr     = (bus.opcd == 3'b110);
                w_done   = 1'b1;
            end
            S_HALT: begin
                w_halt  = 1'b1;
                w_phase = 3'd4;
            end
            default: w_phase = 3'd0;
        endcase
    end

    assign bus.sel        = w_sel;
    assign bus.rd         = w_rd;
    assign bus.ld_ir      = w_ld_ir;
    assign bus.inc_pc     = w_inc_pc;
    assign bus.ld_pc      = w_ld_pc;
    assign bus.ld_ac      = w_ld_ac;
    assign bus.data_e     = w_data_e;
    assign bus.wr         = w_wr;
    assign bus.halt       = w_halt;
    assign bus.paused     = w_paused;
    assign bus.phase      = w_phase;
    assign bus.instr_done = w_done;
    assign bus.instr_cnt  = r_cnt;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Directed bench for risc_ctrl_seq: per-phase strobe vectors for each opcode
// class, run/step/halt control, and counter saturation on a CNTW=2 instance.
module tb_risc_ctrl_seq;
    logic clk = 1'b0;
    logic rst;
    logic rst2;
    logic [3:0] dbg1;
    logic [3:0] dbg2;
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    risc_ctrl_seq_if #(.CNTW(8)) bus1 ();
    risc_ctrl_seq_if #(.CNTW(2)) bus2 ();

    risc_ctrl_seq #(.CNTW(8)) dut1 (.clk(clk), .rst(rst),  .bus(bus1), .o_dbg_state(dbg1));
    risc_ctrl_seq #(.CNTW(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2), .o_dbg_state(dbg2));

    always #5 clk = ~clk;

    // Strobe order: sel rd ld_ir inc_pc ld_pc ld_ac data_e wr halt paused instr_done
    localparam logic [10:0] V_PAUSE = 11'b10000000010;
    localparam logic [10:0] V_HALT  = 11'b00000000100;
    localparam logic [7:0][10:0] V_ADD = {
        11'b01000100001, 11'b01000000000, 11'b01000000000, 11'b00010000000,
        11'b11100000000, 11'b11100000000, 11'b11000000000, 11'b10000000000};
    localparam logic [7:0][10:0] V_STO = {
        11'b00000011001, 11'b00000010000, 11'b00000000000, 11'b00010000000,
        11'b11100000000, 11'b11100000000, 11'b11000000000, 11'b10000000000};
    localparam logic [7:0][10:0] V_SKZ1 = {
        11'b00000000001, 11'b00010000000, 11'b00000000000, 11'b00010000000,
        11'b11100000000, 11'b11100000000, 11'b11000000000, 11'b10000000000};
    localparam logic [7:0][10:0] V_SKZ0 = {
        11'b00000000001, 11'b00000000000, 11'b00000000000, 11'b00010000000,
        11'b11100000000, 11'b11100000000, 11'b11000000000, 11'b10000000000};
    localparam logic [7:0][10:0] V_JMP = {
        11'b00001000001, 11'b00001000000, 11'b00000000000, 11'b00010000000,
        11'b11100000000, 11'b11100000000, 11'b11000000000, 11'b10000000000};

    function automatic logic [10:0] strobes1();
        return {bus1.sel, bus1.rd, bus1.ld_ir, bus1.inc_pc, bus1.ld_pc, bus1.ld_ac,
                bus1.data_e, bus1.wr, bus1.halt, bus1.paused, bus1.instr_done};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walk one instruction on dut1 from P0 to P7, checking phase and strobes.
    task automatic instr(input string name, input logic [2:0] op, input logic z,
                         input logic [7:0][10:0] exp, input int cnt0,
                         input int drop_at, input int step_at);
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            if (p == 0) begin
                bus1.step = 1'b0;
                bus1.opcd = op;
                bus1.zr   = z;
                #1;
                chk($sformatf("%s_cnt", name), 16'(bus1.instr_cnt), 16'(cnt0));
            end
            chk($sformatf("%s_phase%0d", name, p), 16'(bus1.phase), 16'(p));
            chk($sformatf("%s_strb%0d", name, p), 16'(strobes1()), 16'(exp[p]));
            if (p == drop_at) bus1.run  = 1'b0;
            if (p == step_at) bus1.step = 1'b1;
        end
    endtask

    initial begin
        logic [1:0] exp_cnt2 [5];
        exp_cnt2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst  = 1'b1;
        rst2 = 1'b1;
        bus1.run = 1'b0; bus1.step = 1'b0; bus1.opcd = 3'b010; bus1.zr = 1'b0;
        bus2.run = 1'b0; bus2.step = 1'b0; bus2.opcd = 3'b010; bus2.zr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("reset_state", 16'(dbg1), 16'd8);
        chk("reset_strb", 16'(strobes1()), 16'(V_PAUSE));
        chk("reset_phase", 16'(bus1.phase), 16'd0);
        chk("reset_cnt", 16'(bus1.instr_cnt), 16'd0);

        // Back-to-back free run over each opcode class.
        bus1.run = 1'b1;
        instr("add",  3'b010, 1'b0, V_ADD,  0, -1, -1);
        instr("sto",  3'b110, 1'b0, V_STO,  1, -1, -1);
        instr("skz1", 3'b001, 1'b1, V_SKZ1, 2, -1, -1);
        instr("skz0", 3'b001, 1'b0, V_SKZ0, 3, -1, -1);
        instr("jmp",  3'b111, 1'b0, V_JMP,  4, -1, -1);
        instr("and",  3'b011, 1'b0, V_ADD,  5, 3, -1);

        @(negedge clk);
        chk("drop_pause", 16'(dbg1), 16'd8);
        chk("drop_cnt", 16'(bus1.instr_cnt), 16'd6);
        repeat (3) @(negedge clk);
        chk("pause_hold", 16'(strobes1()), 16'(V_PAUSE));

        // Single step; a second step mid-instruction must be ignored.
        bus1.step = 1'b1;
        instr("step", 3'b101, 1'b0, V_ADD, 6, -1, 4);
        @(negedge clk);
        bus1.step = 1'b0;
        chk("step_pause", 16'(dbg1), 16'd8);
        chk("step_cnt", 16'(bus1.instr_cnt), 16'd7);
        @(negedge clk);
        chk("step_not_queued", 16'(dbg1), 16'd8);

        // HLT: halt in P4, then sticky HALT until rst.
        bus1.run  = 1'b1;
        bus1.opcd = 3'b000;
        repeat (5) @(negedge clk);
        chk("hlt_p4_phase", 16'(bus1.phase), 16'd4);
        chk("hlt_p4_strb", 16'(strobes1()), 16'(V_HALT));
        @(negedge clk);
        chk("halt_state", 16'(dbg1), 16'd9);
        chk("halt_strb", 16'(strobes1()), 16'(V_HALT));
        chk("halt_phase", 16'(bus1.phase), 16'd4);
        bus1.run  = 1'b0;
        bus1.step = 1'b1;
        @(negedge clk);
        bus1.step = 1'b0;
        bus1.run  = 1'b1;
        repeat (3) @(negedge clk);
        chk("halt_sticky", 16'(dbg1), 16'd9);
        chk("halt_cnt", 16'(bus1.instr_cnt), 16'd7);
        bus1.run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("halt_rst_state", 16'(dbg1), 16'd8);
        chk("halt_rst_strb", 16'(strobes1()), 16'(V_PAUSE));
        chk("halt_rst_cnt", 16'(bus1.instr_cnt), 16'd0);

        // Saturation on the 2-bit counter, then reset in the middle of P5.
        rst2 = 1'b0;
        bus2.run = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("sat_cnt%0d", i), 16'(bus2.instr_cnt), 16'(exp_cnt2[i]));
            chk($sformatf("sat_phase%0d", i), 16'(bus2.phase), 16'd0);
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("p5_phase", 16'(bus2.phase), 16'd5);
        chk("p5_wr", 16'(bus2.wr), 16'd0);
        rst2 = 1'b1;
        @(negedge clk);
        chk("rst_p5_state", 16'(dbg2), 16'd8);
        chk("rst_p5_wr", 16'(bus2.wr), 16'd0);
        chk("rst_p5_paused", 16'(bus2.paused), 16'd1);
        chk("rst_p5_cnt", 16'(bus2.instr_cnt), 16'd0);
        rst2 = 1'b0;
        bus2.run = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
